// File: rtl/seg_digit_scanner.sv
// +----------------------------------------------------------------------------+
// | seg_digit_scanner                                                          |
// | Double-buffered multiplexed hex digit scanner with per-slot anode dead     |
// | time. Optional macro: SEG_SCAN_LEADING_ZERO_BLANK_EN (leading-zero blank). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module seg_digit_scanner #(
  parameter int NUM_DIGITS       = 4,
  parameter int REFRESH_DIV      = 50000,
  parameter int DEAD_CYCLES      = 4,
  parameter int ANODE_ACTIVE_LOW = 1,
  localparam int c_idx_w         = $clog2(NUM_DIGITS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              digit_value,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [c_idx_w-1:0]      digit_idx,
  output logic                    frame_tick
);

  localparam int c_cnt_w = $clog2(REFRESH_DIV);
  localparam logic [NUM_DIGITS-1:0] c_anodes_off =
    (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [c_cnt_w-1:0]        r_cnt;
  logic [c_cnt_w-1:0]        w_cnt_nxt;
  logic [c_idx_w-1:0]        r_idx;
  logic [c_idx_w-1:0]        w_idx_nxt;
  logic [4*NUM_DIGITS-1:0]   r_shadow;
  logic [4*NUM_DIGITS-1:0]   w_shadow_nxt;
  logic [4*NUM_DIGITS-1:0]   r_active;
  logic [4*NUM_DIGITS-1:0]   w_active_nxt;
  logic                      w_cnt_wrap;
  logic                      w_frame_wrap;
  logic [NUM_DIGITS-1:0]     w_lz_sup;
  logic [NUM_DIGITS-1:0]     w_anodes_on;
  logic [NUM_DIGITS-1:0]     w_anodes_nxt;
  logic [3:0]                w_dv_nxt;
  logic [3:0]                r_digit_value;
  logic [NUM_DIGITS-1:0]     r_anodes;
  logic                      r_frame_tick;

  // Counters and double buffer; a load coinciding with the frame wrap bypasses the shadow.
  always_comb begin
    w_cnt_wrap   = (r_cnt == c_cnt_w'(REFRESH_DIV - 1));
    w_frame_wrap = w_cnt_wrap && (r_idx == c_idx_w'(NUM_DIGITS - 1));
    w_cnt_nxt    = w_cnt_wrap ? '0 : r_cnt + 1'b1;
    if (w_frame_wrap)
      w_idx_nxt = '0;
    else if (w_cnt_wrap)
      w_idx_nxt = r_idx + 1'b1;
    else
      w_idx_nxt = r_idx;
    w_shadow_nxt = load ? value_in : r_shadow;
    w_active_nxt = w_frame_wrap ? w_shadow_nxt : r_active;
  end

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic w_zero_run;

  // Digit i is dark when it and every more significant nibble are zero; digit 0 never is.
  always_comb begin
    w_lz_sup   = '0;
    w_zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_zero_run  = w_zero_run && (w_active_nxt[4*i +: 4] == 4'h0);
      w_lz_sup[i] = w_zero_run;
    end
  end
`else
  assign w_lz_sup = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_dv_nxt    = 4'h0;
    w_anodes_on = '0;
    case (r_state)
      BLANK:   if (w_cnt_nxt == c_cnt_w'(DEAD_CYCLES)) w_state_nxt = DRIVE;
      DRIVE:   if (w_cnt_wrap) w_state_nxt = BLANK;
      default: w_state_nxt = BLANK;
    endcase
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx_nxt == c_idx_w'(i)) begin
        w_dv_nxt       = w_active_nxt[4*i +: 4];
        w_anodes_on[i] = (w_state_nxt == DRIVE) && !blank_mask[i] && !w_lz_sup[i];
      end
    end
    w_anodes_nxt = (ANODE_ACTIVE_LOW != 0) ? ~w_anodes_on : w_anodes_on;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= BLANK;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_shadow      <= '0;
      r_active      <= '0;
      r_digit_value <= 4'h0;
      r_anodes      <= c_anodes_off;
      r_frame_tick  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_shadow      <= w_shadow_nxt;
      r_active      <= w_active_nxt;
      r_digit_value <= w_dv_nxt;
      r_anodes      <= w_anodes_nxt;
      r_frame_tick  <= w_frame_wrap;
    end
  end

  assign digit_value = r_digit_value;
  assign anodes      = r_anodes;
  assign digit_idx   = r_idx;
  assign frame_tick  = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_seg_digit_scanner.sv
// +----------------------------------------------------------------------------+
// | tb_seg_digit_scanner                                                       |
// | Randomized self-checking bench against a cycle-count reference model.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_seg_digit_scanner;
  localparam int N = 4;
  localparam int R = 8;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value_in = 16'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  digit_value;
  logic [3:0]  anodes;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int          n_total = 0;
  int          n_pass = 0;
  int          t = 0;
  logic [15:0] m_shadow = 16'h0;
  logic [15:0] m_active = 16'h0;

  seg_digit_scanner #(
    .NUM_DIGITS(N), .REFRESH_DIV(R), .DEAD_CYCLES(D), .ANODE_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .load(load), .value_in(value_in),
    .blank_mask(blank_mask), .digit_value(digit_value), .anodes(anodes),
    .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s t=%0d got=%0h exp=%0h", tag, t, got, exp);
  endtask

  // t counts edges since reset release; slot, digit and frame follow from it directly.
  task automatic step(input bit ld, input logic [15:0] v);
    logic [3:0] bm, e_an, e_dv;
    int         cnt, idx;
    bit         sup, e_ft;
    load = ld;
    value_in = v;
    bm = blank_mask;
    if (reset) begin
      t = 0;
      m_shadow = 16'h0;
      m_active = 16'h0;
    end else begin
      t++;
      if (t % (N*R) == 0) m_active = ld ? v : m_shadow;
      if (ld) m_shadow = v;
    end
    cnt  = t % R;
    idx  = (t / R) % N;
    e_dv = m_active[4*idx +: 4];
    sup  = bm[idx];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    if (idx >= 1 && (m_active >> (4*idx)) == 16'h0) sup = 1'b1;
`endif
    e_an = (cnt < D || sup) ? 4'hF : ~(4'b0001 << idx);
    e_ft = (t > 0) && (t % (N*R) == 0);
    @(posedge clk);
    #1;
    load = 1'b0;
    check("anodes", anodes, e_an);
    check("digit_idx", digit_idx, idx);
    check("digit_value", digit_value, e_dv);
    check("frame_tick", frame_tick, e_ft);
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 16'($urandom));
  endtask

  // Reset lands between edges; outputs must clear without a clock, and loads are ignored.
  task automatic async_reset_check();
    #2;
    reset = 1'b1;
    #1;
    check("rst_anodes", anodes, 4'hF);
    check("rst_digit_idx", digit_idx, 0);
    check("rst_digit_value", digit_value, 0);
    check("rst_frame_tick", frame_tick, 0);
    step(1'b1, 16'($urandom));
    step(1'b1, 16'($urandom));
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] v;
    int          z;
    step(1'b0, 16'h0);
    step(1'b1, 16'hBEEF);
    reset = 1'b0;
    run(40);

    while (t < 44) run(1);
    step(1'b1, 16'h1A2F);
    while (t < 100) run(1);

    while ((t + 1) % (N*R) != 0) run(1);
    step(1'b1, 16'h00C3);
    run(32);

    step(1'b1, 16'h1234);
    while (t % (N*R) != 0) run(1);
    blank_mask = 4'b0100;
    run(40);
    blank_mask = 4'b0000;

    async_reset_check();
    run(13);
    async_reset_check();
    run(20);

    step(1'b1, 16'h0050);
    run(70);
    step(1'b1, 16'h0000);
    run(70);

    repeat (800) begin
      if ($urandom_range(0, 19) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(0, 299) == 0) async_reset_check();
      if ($urandom_range(0, 5) == 0) begin
        v = 16'($urandom);
        z = $urandom_range(0, 4);
        for (int k = 0; k < z; k++) v[15-4*k -: 4] = 4'h0;
        step(1'b1, v);
      end else begin
        run(1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

`default_nettype wire
